// File: rtl/avl_bus_type.sv
// Shared Avalon bus types and helpers for the avl_bus_12n splitter and its bus interface.
package avl_bus_type;

    localparam int unsigned AVL_ADDR_W  = 32;
    localparam int unsigned AVL_DATA_W  = 32;
    localparam int unsigned AVL_BE_W    = 4;
    localparam int unsigned AVL_BURST_W = 8;

    localparam logic [AVL_DATA_W-1:0] AVL_DECERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_WR_BURST
    } avl_12n_state_t;

    function automatic logic avl_addr_match(input logic [AVL_ADDR_W-1:0] addr,
                                            input logic [AVL_ADDR_W-1:0] base,
                                            input logic [AVL_ADDR_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/i_avl_bus.sv
// Avalon-style command/response bundle shared by masters and slaves.
interface i_avl_bus;
    import avl_bus_type::*;

    logic [AVL_ADDR_W-1:0]  address;
    logic [AVL_BE_W-1:0]    byte_en;
    logic                   read;
    logic                   write;
    logic [AVL_DATA_W-1:0]  write_data;
    logic                   begin_burst_transfer;
    logic [AVL_BURST_W-1:0] burst_count;
    logic                   request_ready;
    logic [AVL_DATA_W-1:0]  read_data;
    logic                   read_data_valid;
    logic                   resp_ready;

    modport master (
        output address, byte_en, read, write, write_data, begin_burst_transfer, burst_count,
        output resp_ready,
        input  request_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, byte_en, read, write, write_data, begin_burst_transfer, burst_count,
        input  resp_ready,
        output request_ready, read_data, read_data_valid
    );

endinterface

// File: rtl/avl_bus_12n_dec.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module avl_bus_12n_dec
    import avl_bus_type::*;
#(
    parameter int unsigned             SLAVE_NUM  = 4,
    parameter logic [SLAVE_NUM*32-1:0] SLAVE_BASE = {SLAVE_NUM{32'h0}},
    parameter logic [SLAVE_NUM*32-1:0] SLAVE_MASK = {SLAVE_NUM{32'hF000_0000}},
    parameter int unsigned             SEL_W      = $clog2(SLAVE_NUM + 1)
) (
    input  logic [AVL_ADDR_W-1:0] address,
    output logic [SEL_W-1:0]      dec_sel,
    output logic                  dec_hit
);

    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < int'(SLAVE_NUM); i++) begin
            if (!dec_hit && avl_addr_match(address, SLAVE_BASE[32*i +: 32],
                                           SLAVE_MASK[32*i +: 32])) begin
                dec_hit = 1'b1;
                dec_sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/avl_bus_12n.sv
// 1-to-N Avalon bus splitter with in-order read return and write-burst target locking.
// Define AVL_BUS_12N_DECERR_EN to enable the internal decode-error responder.
module avl_bus_12n
    import avl_bus_type::*;
#(
    parameter int unsigned             SLAVE_NUM       = 4,
    parameter logic [SLAVE_NUM*32-1:0] SLAVE_BASE      = {SLAVE_NUM{32'h0}},
    parameter logic [SLAVE_NUM*32-1:0] SLAVE_MASK      = {SLAVE_NUM{32'hF000_0000}},
    parameter int unsigned             MAX_OUTSTANDING = 8
) (
    input  logic     clk,
    input  logic     rest,
    i_avl_bus.slave  avl_in,
    i_avl_bus.master avl_out [SLAVE_NUM-1:0],
    output logic     decode_err
);

    localparam int unsigned SEL_W   = $clog2(SLAVE_NUM + 1);
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned BEATS_W = AVL_BURST_W + 1;
`ifdef AVL_BUS_12N_DECERR_EN
    localparam logic [SEL_W-1:0] MISS_SEL = SEL_W'(SLAVE_NUM);
`else
    localparam logic [SEL_W-1:0] MISS_SEL = SEL_W'(SLAVE_NUM - 1);
`endif

    avl_12n_state_t         state_q, state_d;
    logic [SEL_W-1:0]       locked_sel_q, locked_sel_d;
    logic [SEL_W-1:0]       rd_sel_q, rd_sel_d;
    logic [AVL_BURST_W-1:0] wr_left_q, wr_left_d;
    logic [CNT_W-1:0]       rd_cnt_q, rd_cnt_d;

    logic [SEL_W-1:0]      dec_sel, dec_tgt, tgt;
    logic                  dec_hit;
    logic [BEATS_W-1:0]    beats;
    logic                  stall, accept, accept_rd, consume;
    logic [SLAVE_NUM:0]    req_ready_vec, rd_valid_vec;
    logic [AVL_DATA_W-1:0] rd_data_vec [SLAVE_NUM:0];

    avl_bus_12n_dec #(
        .SLAVE_NUM  (SLAVE_NUM),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK),
        .SEL_W      (SEL_W)
    ) u_dec (
        .address (avl_in.address),
        .dec_sel (dec_sel),
        .dec_hit (dec_hit)
    );

    // Index SLAVE_NUM is the error responder; unreachable unless the responder is enabled.
    assign req_ready_vec[SLAVE_NUM] = 1'b1;
    assign rd_valid_vec[SLAVE_NUM]  = 1'b1;
    assign rd_data_vec[SLAVE_NUM]   = AVL_DECERR_DATA;

    always_comb begin
        dec_tgt = dec_hit ? dec_sel : MISS_SEL;
        tgt     = (state_q == ST_WR_BURST) ? locked_sel_q : dec_tgt;
        beats   = (avl_in.begin_burst_transfer && avl_in.burst_count != '0)
                ? {1'b0, avl_in.burst_count} : BEATS_W'(1);
        stall   = 1'b0;
        if (avl_in.read) begin
            if (state_q == ST_WR_BURST) stall = 1'b1;
            if (rd_cnt_q != '0 && dec_tgt != rd_sel_q) stall = 1'b1;
            if ((32'(rd_cnt_q) + 32'(beats)) > MAX_OUTSTANDING) stall = 1'b1;
        end
    end

    assign avl_in.request_ready   = !rest && req_ready_vec[tgt] && !stall;
    assign avl_in.read_data       = rd_data_vec[rd_sel_q];
    assign avl_in.read_data_valid = !rest && rd_valid_vec[rd_sel_q] && rd_cnt_q != '0;

    assign accept    = (avl_in.read || avl_in.write) && avl_in.request_ready;
    assign accept_rd = accept && avl_in.read;
    assign consume   = avl_in.read_data_valid && avl_in.resp_ready;

`ifdef AVL_BUS_12N_DECERR_EN
    assign decode_err = accept && state_q == ST_IDLE && !dec_hit;
`else
    assign decode_err = 1'b0;
`endif

    for (genvar i = 0; i < SLAVE_NUM; i++) begin : g_slave
        localparam logic [SEL_W-1:0] IDX = SEL_W'(i);

        assign avl_out[i].read                 = !rest && avl_in.read && !stall && tgt == IDX;
        assign avl_out[i].write                = !rest && avl_in.write && !stall && tgt == IDX;
        assign avl_out[i].address              = avl_in.address;
        assign avl_out[i].byte_en              = avl_in.byte_en;
        assign avl_out[i].write_data           = avl_in.write_data;
        assign avl_out[i].begin_burst_transfer = avl_in.begin_burst_transfer;
        assign avl_out[i].burst_count          = avl_in.burst_count;
        assign avl_out[i].resp_ready           = avl_in.resp_ready && rd_sel_q == IDX;

        assign req_ready_vec[i] = avl_out[i].request_ready;
        assign rd_valid_vec[i]  = avl_out[i].read_data_valid;
        assign rd_data_vec[i]   = avl_out[i].read_data;
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        rd_sel_d = rd_sel_q;
        if (accept_rd) begin
            rd_cnt_d = rd_cnt_d + CNT_W'(beats);
            rd_sel_d = tgt;
        end
        if (consume) rd_cnt_d = rd_cnt_d - CNT_W'(1);
    end

    // Burst beats after the first carry no decodable address, so the target is latched.
    always_comb begin
        state_d      = state_q;
        locked_sel_d = locked_sel_q;
        wr_left_d    = wr_left_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && avl_in.write && avl_in.begin_burst_transfer
                    && avl_in.burst_count > AVL_BURST_W'(1)) begin
                    state_d      = ST_WR_BURST;
                    locked_sel_d = dec_tgt;
                    wr_left_d    = avl_in.burst_count - AVL_BURST_W'(1);
                end
            end
            ST_WR_BURST: begin
                if (accept && avl_in.write) begin
                    wr_left_d = wr_left_q - AVL_BURST_W'(1);
                    if (wr_left_q == AVL_BURST_W'(1)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q      <= ST_IDLE;
            locked_sel_q <= '0;
            rd_sel_q     <= '0;
            wr_left_q    <= '0;
            rd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            locked_sel_q <= locked_sel_d;
            rd_sel_q     <= rd_sel_d;
            wr_left_q    <= wr_left_d;
            rd_cnt_q     <= rd_cnt_d;
        end
    end

endmodule
